// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side drives start/sub/A/B,
// the adder returns busy/done and the registered result flags.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;

  modport master (
    output start, sub, A, B,
    input  busy, done, Sum, Carry, Overflow
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, Sum, Carry, Overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice resolves one bit per clock, LSB first.
// Subtraction is A + ~B + 1, with the +1 entering through the preset carry flip-flop.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             bit_co;

  assign bit_s  = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_co = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.sub ? ~bus.B : bus.B;
          c_d     = bus.sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d = {bit_s, res_q[WIDTH-1:1]};
        c_d   = bit_co;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // On the MSB slice c_q is the carry into the MSB, bit_co the carry out.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          carry_d = bit_co;
          ovf_d   = c_q ^ bit_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.Sum      = sum_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 4, 2 and 16: vector table, multi-cycle
// corner sequences, and a reference add model for the back-to-back and sweep runs.
module tb_serial_adder;

  logic clk;
  logic reset;

  int n_chk;
  int n_fail;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(4))  if4 ();
  serial_adder_if #(.WIDTH(2))  if2 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8));
  serial_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .reset(reset), .bus(if4));
  serial_adder #(.WIDTH(2))  u_dut2  (.clk(clk), .reset(reset), .bus(if2));
  serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       c;
    logic       v;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Returns {overflow, carry, sum} for a w-bit add or subtract.
  function automatic logic [33:0] ref_add(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] bb;
    logic [32:0] full;
    logic [31:0] sm;
    logic        cy;
    logic        ov;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = a & mask;
    bb   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bb} + {32'h0, s};
    sm   = full[31:0] & mask;
    cy   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (sm[w-1] != am[w-1]);
    return {ov, cy, sm};
  endfunction

  // Launch one WIDTH=8 operation; optionally re-assert start with FF/FF in cycle gk while busy.
  task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic ec, input logic ev,
                     input int gk, input string nm);
    logic       ok;
    logic [9:0] prev;
    ok   = 1'b1;
    prev = {if8.Sum, if8.Carry, if8.Overflow};
    if8.start = 1'b1;
    if8.sub   = s;
    if8.A     = a;
    if8.B     = b;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if8.start = 1'b0;
        if8.A     = ~a;
        if8.B     = ~b;
        if8.sub   = ~s;
      end
      if (k == gk) begin
        if8.start = 1'b1;
        if8.A     = 8'hFF;
        if8.B     = 8'hFF;
      end
      if (k == gk + 1) if8.start = 1'b0;
      if (if8.done !== (k == 9)) ok = 1'b0;
      if (if8.busy !== (k <= 9)) ok = 1'b0;
      if (k <= 8 && {if8.Sum, if8.Carry, if8.Overflow} !== prev) ok = 1'b0;
      if (k == 9) chk({nm, " result"}, {if8.Sum, if8.Carry, if8.Overflow}, {es, ec, ev});
    end
    chk({nm, " timing"}, ok, 1'b1);
  endtask

  initial begin
    logic [3:0]  opa[0:30];
    logic [3:0]  opb[0:30];
    logic        ops[0:30];
    logic [33:0] r;
    logic        ok;

    n_chk  = 0;
    n_fail = 0;

    tbl[0] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};

    reset = 1'b1;
    if8.start  = 1'b0; if8.sub  = 1'b0; if8.A  = '0; if8.B  = '0;
    if4.start  = 1'b0; if4.sub  = 1'b0; if4.A  = '0; if4.B  = '0;
    if2.start  = 1'b0; if2.sub  = 1'b0; if2.A  = '0; if2.B  = '0;
    if16.start = 1'b0; if16.sub = 1'b0; if16.A = '0; if16.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs w8", {if8.busy, if8.done, if8.Sum, if8.Carry, if8.Overflow}, '0);
    chk("reset outputs w16", {if16.busy, if16.done, if16.Sum, if16.Carry, if16.Overflow}, '0);

    // First start coincides with the first cycle of reset low.
    reset = 1'b0;
    for (int i = 0; i < 10; i++)
      go8(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].c, tbl[i].v, 0,
          $sformatf("vec%0d", i));

    go8(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 3, "start while busy");

    // Reset in RUN cycle 4 aborts the operation with no done pulse.
    if8.start = 1'b1; if8.sub = 1'b0; if8.A = 8'h7F; if8.B = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) if8.start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid-run reset outputs", {if8.busy, if8.done, if8.Sum, if8.Carry, if8.Overflow}, '0);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (if8.done !== 1'b0 || if8.busy !== 1'b0) ok = 1'b0;
    end
    chk("no done after abort", ok, 1'b1);
    go8(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0, "after abort");

    // WIDTH=4, start held high for 30 cycles with operands changing every cycle.
    for (int c = 0; c <= 30; c++) begin
      opa[c] = 4'((c * 3 + 1) & 15);
      opb[c] = 4'((c * 5 + 2) & 15);
      ops[c] = 1'((c / 6) & 1);
    end
    if4.start = 1'b1; if4.A = opa[0]; if4.B = opb[0]; if4.sub = ops[0];
    for (int p = 1; p <= 30; p++) begin
      @(posedge clk);
      #1;
      if (p < 30) begin
        if4.A = opa[p]; if4.B = opb[p]; if4.sub = ops[p];
      end else begin
        if4.start = 1'b0;
      end
      chk($sformatf("w4 done cycle %0d", p), if4.done, (p % 6) == 5);
      if ((p % 6) == 5) begin
        r = ref_add(4, ops[p-5], 32'(opa[p-5]), 32'(opb[p-5]));
        chk($sformatf("w4 result cycle %0d", p), {if4.Sum, if4.Carry, if4.Overflow},
            {r[3:0], r[32], r[33]});
      end
    end

    // WIDTH=2 exhaustive sweep.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          r  = ref_add(2, 1'(s), 32'(a), 32'(b));
          ok = 1'b1;
          if2.start = 1'b1; if2.sub = 1'(s); if2.A = 2'(a); if2.B = 2'(b);
          for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) if2.start = 1'b0;
            if (if2.done !== (k == 3)) ok = 1'b0;
            if (k == 3 && {if2.Sum, if2.Carry, if2.Overflow} !== {r[1:0], r[32], r[33]})
              ok = 1'b0;
          end
          chk($sformatf("w2 s=%0d a=%0d b=%0d", s, a, b), ok, 1'b1);
        end
      end
    end

    // WIDTH=16 random sweep.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      a  = 16'($urandom());
      b  = 16'($urandom());
      s  = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 16'h7FFF; b = 16'h0001; s = 1'b0; end
      if (i == 1) begin a = 16'h8000; b = 16'h0001; s = 1'b1; end
      r  = ref_add(16, s, 32'(a), 32'(b));
      ok = 1'b1;
      if16.start = 1'b1; if16.sub = s; if16.A = a; if16.B = b;
      for (int k = 1; k <= 18; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) if16.start = 1'b0;
        if (if16.done !== (k == 17)) ok = 1'b0;
        if (k == 17 && {if16.Sum, if16.Carry, if16.Overflow} !== {r[15:0], r[32], r[33]})
          ok = 1'b0;
      end
      chk($sformatf("w16 %0d s=%0d a=%h b=%h", i, s, a, b), ok, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: sub  input  1  mode: 0 = A+B, 1 = A-B; captured with operands.
REQ-006 Port: A  input  WIDTH  first operand; captured when start accepted.
REQ-007 Port: B  input  WIDTH  second operand; captured when start accepted.
REQ-008 Port: busy  output  1  high in RUN and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: Sum  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-011 Port: Carry  output  1  carry out of MSB; in subtract mode 1 = no borrow, 0 = borrow.
REQ-012 Port: Overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-013 Datapath: one full-adder bit slice (XOR/AND/OR of LSB bits plus carry flip-flop) processes one bit per clock, LSB first.
REQ-014 States: IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: start=1 -> capture A into shift register A_r, B (or ~B when sub=1) into B_r, carry FF <= sub, bit counter <= 0, go RUN; start=0 -> stay IDLE.
REQ-016 RUN: each cycle, result bit = A_r[0]^B_r[0]^c shifted into result register MSB end; c <= majority(A_r[0],B_r[0],c); A_r, B_r shift right; counter increments.
REQ-017 RUN -> DONE on the cycle the counter reaches WIDTH-1 (exactly WIDTH RUN cycles).
REQ-018 On the RUN->DONE edge: Sum <= full result, Carry <= final c, Overflow <= carry into MSB XOR carry out of MSB.
REQ-019 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-020 Latency: start high in cycle 0 -> done high in cycle WIDTH+1; next start accepted in cycle WIDTH+2 at earliest.
REQ-021 start, sub, A, B are ignored while busy=1; operand changes during RUN have no effect on the result.
REQ-022 Sum, Carry, Overflow hold their last value until the next RUN->DONE edge; they do not change during RUN.
REQ-023 start held high continuously -> back-to-back operations, one every WIDTH+2 cycles, each using operands present in its accepting IDLE cycle.
REQ-024 Subtract implemented as A + ~B + 1 only; no separate subtractor.

Reset
REQ-025 reset=1 at a rising edge -> state IDLE, busy=0, done=0, Sum=0, Carry=0, Overflow=0, counter=0, carry FF=0, shift registers=0.
REQ-026 reset has priority over start and over every state transition, including mid-RUN and in DONE.
REQ-027 Reset asserted mid-RUN aborts the operation; no done pulse is produced for it.
REQ-028 First start is accepted in the first cycle with reset=0.

Verification
REQ-029 WIDTH=8, sub=0, A=8'hFF, B=8'h01, start 1 cycle at cycle 0 -> done=1 only in cycle 9; Sum=8'h00, Carry=1, Overflow=0.
REQ-030 WIDTH=8, sub=0, A=8'h7F, B=8'h01 -> Sum=8'h80, Carry=0, Overflow=1; A=8'h80, B=8'h80 -> Sum=8'h00, Carry=1, Overflow=1.
REQ-031 WIDTH=8, sub=1, A=8'h05, B=8'h07 -> Sum=8'hFE, Carry=0, Overflow=0; A=8'h80, B=8'h01 -> Sum=8'h7F, Carry=1, Overflow=1.
REQ-032 Start 8'h10+8'h20; in cycle 3 drive start=1, A=8'hFF, B=8'hFF -> ignored; result Sum=8'h30, done in cycle 9 only.
REQ-033 Reset pulsed in RUN cycle 4 -> next cycle busy=0, all outputs 0, no done; fresh start then completes with correct result.
REQ-034 start held high 30 cycles with WIDTH=4, operands changing each cycle -> done in cycles 5, 11, 17, 23, 29; each result matches operands from cycles 0, 6, 12, 18, 24; plus random sweep of WIDTH=2 and WIDTH=16 against a reference adder model.
